param_stack: RTL and testbench
==============================

# param_stack

Parametrised synchronous LIFO stack for the 19-bit CPU, replacing the fixed 19x32 stack used for call/return and operand storage. All state changes happen on one clock edge. The block adds full/empty status, occupancy count, sticky overflow/underflow errors, a combinational top-of-stack peek and defined simultaneous push+pop behaviour. It sits between the control unit, which issues PUSH/POP/CLR strobes, and the datapath, which supplies and consumes stack words.

## Interface
- WIDTH, 19, data word width in bits.
- DEPTH, 32, number of entries; any integer 2..1024, need not be a power of two.
- PW, $clog2(DEPTH+1), local parameter: width of count.
- CLK  in  1  clock; all state updates on rising edge.
- RST_N  in  1  reset; asynchronous, active-low.
- CLR  in  1  synchronous clear; highest priority of the strobes.
- PUSH  in  1  push inpData this cycle.
- POP  in  1  pop top entry this cycle.
- inpData  in  WIDTH  data to push.
- opData  out  WIDTH  registered; last popped word.
- TOS  out  WIDTH  combinational; current top entry, 0 when EMPTY.
- count  out  PW  registered; number of valid entries, 0..DEPTH.
- EMPTY  out  1  count == 0.
- FULL  out  1  count == DEPTH.
- OVF  out  1  sticky; a push was rejected because the stack was full.
- UNF  out  1  sticky; a pop was rejected because the stack was empty.

## Operation
- Storage: DEPTH x WIDTH register array plus stack pointer sp, equal to count. Entry sp-1 is the top.
- Reset (RST_N low, asynchronous): count=0, opData=0, OVF=0, UNF=0, EMPTY=1, FULL=0, TOS=0. Array contents are don't-care and are not cleared.
- Per-edge priority, evaluated on strobes sampled at the rising edge:
  - CLR=1: count=0, OVF=0, UNF=0; opData holds; PUSH/POP that cycle are ignored.
  - PUSH=1, POP=0, not FULL: mem[count]=inpData, count+1.
  - PUSH=1, POP=0, FULL: no write, count unchanged, OVF=1.
  - POP=1, PUSH=0, not EMPTY: opData=mem[count-1], count-1.
  - POP=1, PUSH=0, EMPTY: opData holds, UNF=1.
  - PUSH=1, POP=1, not EMPTY (including FULL): replace. opData=old top, mem[count-1]=inpData, count unchanged, no OVF/UNF.
  - PUSH=1, POP=1, EMPTY: plain push. mem[0]=inpData, count=1, opData holds, UNF not set.
  - Neither strobe: hold everything.
- Strobes are levels sampled every edge. Holding PUSH high for N cycles performs N pushes, so the control unit must pulse them for one cycle.
- OVF and UNF clear only on reset or CLR.
- Data is opaque: no sign handling. inpData is stored bit-exact.

## Timing
- Push: entry is visible on TOS and count increments one cycle after the edge that samples PUSH.
- Pop latency: opData is valid after the sampling edge, one cycle, and holds until the next accepted pop.
- TOS, EMPTY and FULL are derived combinationally from count and the array. There is no additional latency beyond count.
- Back-to-back operations at full rate are supported on every cycle without bubbles.
- Asynchronous reset takes effect mid-operation, with no ordering against the clock. Deassertion is synchronised externally to CLK.
- Wrap-around never occurs: sp saturates at 0 and DEPTH, and error flags mark rejected operations.

## Test plan
- Reset, then push 1123, 235, -9867 (0x7D975), then pop twice -> count=3 after the pushes; opData=0x7D975 then 235; count=1; TOS=1123.
- CLR with one entry present, then push 167 and pop -> after CLR, count=0 and EMPTY=1; after the pop, opData=167, EMPTY=1, OVF=UNF=0.
- Push DEPTH words (values 1..32), then push 99 -> FULL=1, OVF=1, count=32, TOS=32. Pop 32 times -> opData sequence 32..1, then EMPTY=1.
- Pop on empty -> UNF=1, opData unchanged, count=0. Then CLR -> UNF=0.
- PUSH+POP with stack holding 5,6 and inpData=7 -> opData=6, TOS=7, count=2. PUSH+POP on empty with inpData=8 -> count=1, TOS=8, UNF=0.
- Assert RST_N low between clock edges during a push burst -> all outputs return to reset values immediately. After release, a push of 42 gives TOS=42 and count=1.

Source files
------------

// File: rtl/param_stack_if.sv
// rtl/param_stack_if.sv - strobe/data bundle between control unit, datapath and param_stack
// Purpose: groups the stack command strobes, push data and status/result outputs.
// Ports (signals):
//   CLR, PUSH, POP   command strobes, sampled every rising edge
//   inpData          word to push
//   opData           last popped word (registered)
//   TOS              current top entry, 0 when empty (combinational)
//   count            number of valid entries
//   EMPTY, FULL      occupancy status
//   OVF, UNF         sticky rejected-push / rejected-pop flags
// Modports: master = control unit / datapath side, slave = stack side.
interface param_stack_if #(
  parameter int WIDTH = 19,
  parameter int DEPTH = 32
);
  localparam int PW = $clog2(DEPTH + 1);

  logic             CLR;
  logic             PUSH;
  logic             POP;
  logic [WIDTH-1:0] inpData;
  logic [WIDTH-1:0] opData;
  logic [WIDTH-1:0] TOS;
  logic [PW-1:0]    count;
  logic             EMPTY;
  logic             FULL;
  logic             OVF;
  logic             UNF;

  modport master (
    output CLR, PUSH, POP, inpData,
    input  opData, TOS, count, EMPTY, FULL, OVF, UNF
  );

  modport slave (
    input  CLR, PUSH, POP, inpData,
    output opData, TOS, count, EMPTY, FULL, OVF, UNF
  );
endinterface

// File: rtl/param_stack.sv
// rtl/param_stack.sv - parametrised synchronous LIFO stack with status and sticky errors
// Purpose: DEPTH x WIDTH register-array stack; sp (== count) points one past the top.
// Ports:
//   CLK    clock, all state updates on rising edge
//   RST_N  asynchronous active-low reset
//   bus    param_stack_if.slave: CLR/PUSH/POP/inpData in;
//          opData/TOS/count/EMPTY/FULL/OVF/UNF out
module param_stack #(
  parameter int WIDTH = 19,
  parameter int DEPTH = 32
) (
  input  logic         CLK,
  input  logic         RST_N,
  param_stack_if.slave bus
);
  localparam int PW = $clog2(DEPTH + 1);
  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PW-1:0]    sp;
  logic [WIDTH-1:0] op_q;
  logic             ovf_q;
  logic             unf_q;

  logic             empty;
  logic             full;
  logic [AW-1:0]    top_idx;
  logic [AW-1:0]    push_idx;
  logic [AW-1:0]    wr_idx;
  logic             wr_en;

  assign empty    = (sp == '0);
  assign full     = (sp == PW'(DEPTH));
  // top_idx is meaningless when empty; every user qualifies it with !empty.
  assign top_idx  = AW'(sp - PW'(1));
  assign push_idx = AW'(sp);

  // A simultaneous push+pop on a non-empty stack overwrites the top in place;
  // every other accepted push lands at sp (which is 0 when empty).
  assign wr_en  = !bus.CLR && bus.PUSH && (bus.POP || !full);
  assign wr_idx = (bus.POP && !empty) ? top_idx : push_idx;

  // Array contents are not reset.
  always_ff @(posedge CLK) begin
    if (wr_en) begin
      mem[wr_idx] <= bus.inpData;
    end
  end

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      sp    <= '0;
      op_q  <= '0;
      ovf_q <= 1'b0;
      unf_q <= 1'b0;
    end else if (bus.CLR) begin
      sp    <= '0;
      ovf_q <= 1'b0;
      unf_q <= 1'b0;
    end else begin
      case ({bus.PUSH, bus.POP})
        2'b10: begin
          if (full) ovf_q <= 1'b1;
          else      sp    <= sp + PW'(1);
        end
        2'b01: begin
          if (empty) begin
            unf_q <= 1'b1;
          end else begin
            op_q <= mem[top_idx];
            sp   <= sp - PW'(1);
          end
        end
        2'b11: begin
          // Replace: old top goes out, new word takes its slot, depth unchanged.
          if (empty) sp   <= PW'(1);
          else       op_q <= mem[top_idx];
        end
        default: ;
      endcase
    end
  end

  assign bus.opData = op_q;
  assign bus.TOS    = empty ? '0 : mem[top_idx];
  assign bus.count  = sp;
  assign bus.EMPTY  = empty;
  assign bus.FULL   = full;
  assign bus.OVF    = ovf_q;
  assign bus.UNF    = unf_q;
endmodule

// File: tb/tb_param_stack.sv
// tb/tb_param_stack.sv - self-checking bench for param_stack against a queue model
module tb_param_stack;
  localparam int WIDTH = 19;
  localparam int DEPTH = 32;

  logic clk;
  logic rst_n;

  param_stack_if #(.WIDTH(WIDTH), .DEPTH(DEPTH)) bus ();

  param_stack #(.WIDTH(WIDTH), .DEPTH(DEPTH)) dut (
    .CLK   (clk),
    .RST_N (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  // Reference model: a queue whose back is the top of stack.
  logic [WIDTH-1:0] m_q [$];
  logic [WIDTH-1:0] m_op;
  logic             m_ovf;
  logic             m_unf;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    m_q.delete();
    m_op  = '0;
    m_ovf = 1'b0;
    m_unf = 1'b0;
  endtask

  task automatic model_apply(input logic c, input logic p, input logic o,
                             input logic [WIDTH-1:0] d);
    if (c) begin
      m_q.delete();
      m_ovf = 1'b0;
      m_unf = 1'b0;
    end else if (p && !o) begin
      if (m_q.size() == DEPTH) m_ovf = 1'b1;
      else                     m_q.push_back(d);
    end else if (o && !p) begin
      if (m_q.size() == 0) m_unf = 1'b1;
      else                 m_op  = m_q.pop_back();
    end else if (p && o) begin
      if (m_q.size() == 0) begin
        m_q.push_back(d);
      end else begin
        m_op = m_q[m_q.size()-1];
        m_q[m_q.size()-1] = d;
      end
    end
  endtask

  task automatic compare_all(input string tag);
    logic [WIDTH-1:0] exp_tos;
    exp_tos = (m_q.size() == 0) ? '0 : m_q[m_q.size()-1];
    check({tag, ".count"}, 32'(bus.count), 32'(m_q.size()));
    check({tag, ".empty"}, 32'(bus.EMPTY), 32'(m_q.size() == 0));
    check({tag, ".full"},  32'(bus.FULL),  32'(m_q.size() == DEPTH));
    check({tag, ".tos"},   32'(bus.TOS),   32'(exp_tos));
    check({tag, ".op"},    32'(bus.opData), 32'(m_op));
    check({tag, ".ovf"},   32'(bus.OVF),   32'(m_ovf));
    check({tag, ".unf"},   32'(bus.UNF),   32'(m_unf));
  endtask

  task automatic step(input string tag, input logic c, input logic p, input logic o,
                      input logic [WIDTH-1:0] d);
    @(negedge clk);
    bus.CLR = c; bus.PUSH = p; bus.POP = o; bus.inpData = d;
    @(posedge clk);
    model_apply(c, p, o, d);
    #1;
    compare_all(tag);
  endtask

  task automatic idle();
    @(negedge clk);
    bus.CLR = 1'b0; bus.PUSH = 1'b0; bus.POP = 1'b0;
  endtask

  initial begin
    bus.CLR = 1'b0; bus.PUSH = 1'b0; bus.POP = 1'b0; bus.inpData = '0;
    rst_n = 1'b0;
    model_reset();
    #12;
    compare_all("reset");
    @(negedge clk);
    rst_n = 1'b1;

    // Basic push/pop with a negative pattern
    step("tp1_push", 1'b0, 1'b1, 1'b0, 19'd1123);
    step("tp1_push", 1'b0, 1'b1, 1'b0, 19'd235);
    step("tp1_push", 1'b0, 1'b1, 1'b0, 19'h7D975);
    check("tp1_count3", 32'(bus.count), 32'd3);
    step("tp1_pop", 1'b0, 1'b0, 1'b1, '0);
    check("tp1_op0", 32'(bus.opData), 32'h7D975);
    step("tp1_pop", 1'b0, 1'b0, 1'b1, '0);
    check("tp1_op1", 32'(bus.opData), 32'd235);
    check("tp1_tos", 32'(bus.TOS), 32'd1123);

    // CLR then push/pop
    step("tp2_clr",  1'b1, 1'b1, 1'b0, 19'd5);
    check("tp2_empty", 32'(bus.EMPTY), 32'd1);
    step("tp2_push", 1'b0, 1'b1, 1'b0, 19'd167);
    step("tp2_pop",  1'b0, 1'b0, 1'b1, '0);
    check("tp2_op", 32'(bus.opData), 32'd167);

    // Fill, overflow, drain
    for (int i = 1; i <= DEPTH; i++) step("tp3_fill", 1'b0, 1'b1, 1'b0, 19'(i));
    step("tp3_ovf", 1'b0, 1'b1, 1'b0, 19'd99);
    check("tp3_full", 32'(bus.FULL), 32'd1);
    check("tp3_ovf_set", 32'(bus.OVF), 32'd1);
    check("tp3_tos32", 32'(bus.TOS), 32'd32);
    step("tp3_replace_full", 1'b0, 1'b1, 1'b1, 19'd77);
    check("tp3_rep_op", 32'(bus.opData), 32'd32);
    for (int i = DEPTH; i >= 1; i--) step("tp3_drain", 1'b0, 1'b0, 1'b1, '0);
    check("tp3_last_op", 32'(bus.opData), 32'd1);

    // Underflow then CLR
    step("tp4_unf", 1'b0, 1'b0, 1'b1, '0);
    check("tp4_unf_set", 32'(bus.UNF), 32'd1);
    check("tp4_op_hold", 32'(bus.opData), 32'd1);
    step("tp4_clr", 1'b1, 1'b0, 1'b0, '0);
    check("tp4_unf_clr", 32'(bus.UNF), 32'd0);

    // Simultaneous push+pop
    step("tp5_push", 1'b0, 1'b1, 1'b0, 19'd5);
    step("tp5_push", 1'b0, 1'b1, 1'b0, 19'd6);
    step("tp5_pp",   1'b0, 1'b1, 1'b1, 19'd7);
    check("tp5_op6",  32'(bus.opData), 32'd6);
    check("tp5_tos7", 32'(bus.TOS), 32'd7);
    step("tp5_clr",  1'b1, 1'b0, 1'b0, '0);
    step("tp5_ppe",  1'b0, 1'b1, 1'b1, 19'd8);
    check("tp5_tos8", 32'(bus.TOS), 32'd8);

    // Randomised: alternate push-biased and pop-biased phases to hit both ends
    for (int ph = 0; ph < 8; ph++) begin
      for (int i = 0; i < 60; i++) begin
        int r;
        logic c, p, o;
        r = int'($urandom_range(0, 99));
        c = (r < 2);
        if (ph[0] == 1'b0) begin
          p = (r >= 2 && r < 75) || (r >= 90);
          o = (r >= 75);
        end else begin
          p = (r >= 2 && r < 25) || (r >= 90);
          o = (r >= 25);
        end
        step("rnd", c, p, o, 19'($urandom));
      end
    end

    // Async reset mid-cycle during a push burst
    step("tp6_push", 1'b0, 1'b1, 1'b0, 19'd11);
    step("tp6_push", 1'b0, 1'b1, 1'b0, 19'd12);
    @(negedge clk);
    bus.PUSH = 1'b1; bus.inpData = 19'd13;
    @(posedge clk);
    model_apply(1'b0, 1'b1, 1'b0, 19'd13);
    #2;
    rst_n = 1'b0;
    model_reset();
    #1;
    compare_all("tp6_async_rst");
    idle();
    rst_n = 1'b1;
    step("tp6_push42", 1'b0, 1'b1, 1'b0, 19'd42);
    check("tp6_tos42", 32'(bus.TOS), 32'd42);
    check("tp6_cnt1",  32'(bus.count), 32'd1);
    idle();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
